muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Multi-cycle integer multiply/divide engine in the execute stage; consumes decoded
//  MULT/MULTU/DIV/DIVU operands and produces the {hi,lo} result for the hilo writeback.
//  Exposes a busy flag to the hazard unit so younger HI/LO users stall until done.
//  Radix-2 restoring divider; multiplier is a registered product held MUL_LAT cycles.
// PARAMETERS
//  MUL_LAT   2   cycles from accepted start to done for MULT/MULTU (>=1)
//  DIV_ITER  32  divider iterations (fixed; equals operand width)
// PORTS
//  clk      in   1   clock, rising edge
//  resetn   in   1   asynchronous active-low reset
//  start    in   1   request; accepted when start && !busy && !flush
//  op       in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled on accept)
//  a        in   32  rs operand (sampled on accept)
//  b        in   32  rt operand (sampled on accept)
//  flush    in   1   abort in-flight op (exception/flushE)
//  busy     out  1   1 while state is MUL or DIV
//  done     out  1   one-cycle pulse: hi/lo valid, writeback may latch
//  hi       out  32  MULT*: product[63:32]; DIV*: remainder
//  lo       out  32  MULT*: product[31:0];  DIV*: quotient
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0,
//   all datapath regs cleared; abort any in-flight op, no done afterwards.
//  States: IDLE, MUL, DIV, DONE.
//   IDLE/DONE --accept, op[1]=0--> MUL (cnt=MUL_LAT-1, product registered on accept)
//   IDLE/DONE --accept, op[1]=1--> DIV (cnt=DIV_ITER-1, load |a|,|b| or raw for DIVU)
//   MUL: cnt-- each cycle; cnt==0 -> DONE.  DIV: one shift/subtract per cycle;
//   after final iteration -> DONE with sign fixup applied in the same edge.
//   DONE: done=1 for exactly one cycle, then IDLE unless a new start is accepted.
//   Back-to-back: start accepted in DONE cycle; next op begins, done drops.
//  Latency (accept edge to done=1): MULT* = MUL_LAT cycles; DIV* = 32 cycles.
//  hi/lo update only on entry to DONE; hold otherwise (across IDLE, new ops, flush).
//  start while busy: ignored, no effect on state or operands.
//  Signed: MULT = signed 64-bit a*b. DIV: quotient sign = a[31]^b[31],
//   remainder sign = a[31]; magnitudes from unsigned restoring divide of |a|,|b|.
//  DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
//  Divide by zero (DIV or DIVU): lo=0xFFFFFFFF, hi=a (raw operand); latency unchanged.
//  flush: highest priority. Any state -> IDLE next edge; busy=0, done=0 next cycle;
//   hi/lo unchanged; flush with start same cycle: start NOT accepted.
//   flush while in DONE: done still seen this cycle, suppresses nothing already driven.
//  busy, done, hi, lo are registered outputs (no comb path from inputs).
// TESTING
//  1 MULT a=0xFFFFFFFF b=2 -> done after MUL_LAT; hi=0xFFFFFFFF lo=0xFFFFFFFE.
//  2 MULTU a=0xFFFFFFFF b=2 -> hi=0x00000001 lo=0xFFFFFFFE; busy high MUL_LAT cycles.
//  3 DIV a=-7 b=2 -> done 32 cycles after accept; lo=0xFFFFFFFD hi=0xFFFFFFFF;
//    DIVU a=100 b=7 -> lo=0x0000000E hi=0x00000002.
//  4 DIVU a=0x1234 b=0 -> lo=0xFFFFFFFF hi=0x00001234; DIV 0x80000000/-1 -> lo=0x80000000 hi=0.
//  5 DIV started, flush at cycle 10 with start=1 -> IDLE, no done, hi/lo keep prior
//    values; new start next cycle accepted and completes normally.
//  6 start asserted during DIV -> ignored; start in DONE cycle -> accepted back-to-back;
//    resetn low mid-MUL -> all outputs 0 immediately, no done after release.

Source files
------------

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Multi-cycle integer multiply/divide engine for the execute stage. It takes
//   decoded MULT/MULTU/DIV/DIVU operands and produces {hi,lo} for the HI/LO
//   writeback. While an operation is in flight, busy is raised so that the
//   hazard unit can stall younger HI/LO users.
//
//   The multiplier registers the full 64-bit product on accept. It then
//   counts MUL_LAT cycles before it reports the result. The divider is a
//   radix-2 restoring divider that performs one shift/subtract per cycle on
//   operand magnitudes. The sign fixup is applied on the final iteration
//   edge.
//
// Ports
//   clk     in   1   clock, rising edge
//   resetn  in   1   asynchronous active-low reset
//   start   in   1   request, accepted when start && !busy && !flush
//   op      in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled on accept)
//   a       in   32  rs operand (sampled on accept)
//   b       in   32  rt operand (sampled on accept)
//   flush   in   1   abort any in-flight operation; wins over start
//   busy    out  1   operation in progress (state MUL or DIV)
//   done    out  1   one-cycle pulse, hi/lo valid
//   hi      out  32  product[63:32] or remainder
//   lo      out  32  product[31:0]  or quotient
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int MUL_LAT  = 2,
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_MAX = (MUL_LAT > DIV_ITER) ? MUL_LAT : DIV_ITER;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] MUL_CNT0 = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT0 = CNT_W'(DIV_ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Magnitude of a possibly-signed operand; 0x80000000 maps onto itself,
    // which is the correct unsigned magnitude.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [31:0] apply_sign(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      prod_q, prod_d;
    logic [31:0]      rem_q, rem_d;
    logic [31:0]      quo_q, quo_d;
    logic [31:0]      dvs_q, dvs_d;
    logic [31:0]      araw_q, araw_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic             accept;
    logic             op_signed;
    logic [63:0]      mul_a, mul_b, mul_prod;
    logic [32:0]      rem_sh, rem_diff;
    logic             step_ge;
    logic [31:0]      rem_step, quo_step;

    assign accept    = start && !busy_q && !flush;
    assign op_signed = ~op[0];

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
    // correct for both MULT and MULTU.
    assign mul_a    = {{32{a[31] & op_signed}}, a};
    assign mul_b    = {{32{b[31] & op_signed}}, b};
    assign mul_prod = mul_a * mul_b;

    // One restoring-divide step: shift in the next dividend bit and subtract
    // the divisor when it fits. The partial remainder stays below the
    // divisor, so bit 32 of the difference is a clean borrow flag.
    assign rem_sh   = {rem_q, quo_q[31]};
    assign rem_diff = rem_sh - {1'b0, dvs_q};
    assign step_ge  = ~rem_diff[32];
    assign rem_step = step_ge ? rem_diff[31:0] : rem_sh[31:0];
    assign quo_step = {quo_q[30:0], step_ge};

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) state_d = op[1] ? S_DIV : S_MUL;
                    else        state_d = S_IDLE;
                end
                S_MUL, S_DIV: begin
                    if (cnt_q == '0) state_d = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- datapath / counter ----------------
    always_comb begin
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        araw_d  = araw_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        if (accept) begin
            cnt_d   = op[1] ? DIV_CNT0 : MUL_CNT0;
            prod_d  = mul_prod;
            rem_d   = '0;
            quo_d   = magnitude(a, op_signed);
            dvs_d   = magnitude(b, op_signed);
            araw_d  = a;
            q_neg_d = op_signed & (a[31] ^ b[31]);
            r_neg_d = op_signed & a[31];
            dz_d    = (b == 32'd0);
        end else if (!flush && (state_q == S_MUL || state_q == S_DIV)) begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            if (state_q == S_DIV) begin
                rem_d = rem_step;
                quo_d = quo_step;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q   <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            araw_q  <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            araw_q  <= araw_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
        end
    end

    // ---------------- output logic ----------------
    // Outputs are derived from the next state and registered, so there is no
    // combinational path from the inputs. hi/lo change only on entry to DONE.
    always_comb begin
        busy_d = (state_d == S_MUL) || (state_d == S_DIV);
        done_d = (state_d == S_DONE);
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (state_d == S_DONE && state_q == S_MUL) begin
            hi_d = prod_q[63:32];
            lo_d = prod_q[31:0];
        end else if (state_d == S_DONE && state_q == S_DIV) begin
            if (dz_q) begin
                hi_d = araw_q;
                lo_d = 32'hFFFF_FFFF;
            end else begin
                hi_d = apply_sign(rem_step, r_neg_q);
                lo_d = apply_sign(quo_step, q_neg_q);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Self-checking bench for muldiv_unit. Expected {hi,lo} values come from
//   plain 64-bit arithmetic on the operands. Expected latencies come from the
//   operation class.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 32;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.MUL_LAT(MUL_LAT), .DIV_ITER(32)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference result {hi,lo} for one operation.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                               input logic [31:0] y);
        longint          sx, sy, q, r;
        longint unsigned ux, uy, uq, ur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            2'd0: return sx * sy;
            2'd1: return ux * uy;
            2'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                uq = ux / uy;
                ur = ux % uy;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] o);
        return o[1] ? DIV_LAT : MUL_LAT;
    endfunction

    // Issue one operation and wait (bounded) for done. lat counts cycles
    // from the accept edge to the first cycle with done=1.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int bcnt,
                          output logic [31:0] h, output logic [31:0] l);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        bcnt = 0;
        while (!done && lat < 200) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        h = hi;
        l = lo;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        logic [1:0]  ops [2] = '{2'd0, 2'd1};
        int          lat, bcnt;
        logic [31:0] h, l;
        logic [63:0] exp;
        for (int i = 0; i < 2; i++) begin
            exp = ref_result(ops[i], 32'hFFFF_FFFF, 32'd2);
            run_op(ops[i], 32'hFFFF_FFFF, 32'd2, lat, bcnt, h, l);
            checks++; if (h !== exp[63:32]) begin errors++; $display("FAIL mul_hi op=%0d: got %h expected %h", ops[i], h, exp[63:32]); end
            checks++; if (l !== exp[31:0]) begin errors++; $display("FAIL mul_lo op=%0d: got %h expected %h", ops[i], l, exp[31:0]); end
            checks++; if (lat != MUL_LAT) begin errors++; $display("FAIL mul_latency op=%0d: got %0d expected %0d", ops[i], lat, MUL_LAT); end
            checks++; if (bcnt != MUL_LAT) begin errors++; $display("FAIL mul_busy_cycles op=%0d: got %0d expected %0d", ops[i], bcnt, MUL_LAT); end
            @(negedge clk);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse op=%0d: got %b expected 0", ops[i], done); end
        end
    endtask

    task automatic test_div();
        logic [1:0]  ops [4] = '{2'd2, 2'd3, 2'd3, 2'd2};
        logic [31:0] xs  [4] = '{32'hFFFF_FFF9, 32'd100, 32'h0000_1234, 32'h8000_0000};
        logic [31:0] ys  [4] = '{32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
        int          lat, bcnt;
        logic [31:0] h, l;
        logic [63:0] exp;
        for (int i = 0; i < 4; i++) begin
            exp = ref_result(ops[i], xs[i], ys[i]);
            run_op(ops[i], xs[i], ys[i], lat, bcnt, h, l);
            checks++; if (h !== exp[63:32]) begin errors++; $display("FAIL div_hi case=%0d: got %h expected %h", i, h, exp[63:32]); end
            checks++; if (l !== exp[31:0]) begin errors++; $display("FAIL div_lo case=%0d: got %h expected %h", i, l, exp[31:0]); end
            checks++; if (lat != DIV_LAT) begin errors++; $display("FAIL div_latency case=%0d: got %0d expected %0d", i, lat, DIV_LAT); end
        end
    endtask

    task automatic test_flush();
        int          lat, bcnt, dcnt;
        logic [31:0] h, l, h0, l0;
        logic [63:0] exp;
        run_op(2'd3, 32'd100, 32'd7, lat, bcnt, h0, l0);
        @(negedge clk);
        start = 1'b1; op = 2'd2; a = 32'hFFFF_FFCE; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1; start = 1'b1; op = 2'd1; a = 32'd9; b = 32'd9;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_done: got %b expected 0", done); end
        checks++; if (hi !== h0) begin errors++; $display("FAIL flush_hi_hold: got %h expected %h", hi, h0); end
        checks++; if (lo !== l0) begin errors++; $display("FAIL flush_lo_hold: got %h expected %h", lo, l0); end
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        checks++; if (dcnt != 0) begin errors++; $display("FAIL flush_no_done: got %0d active cycles expected 0", dcnt); end
        exp = ref_result(2'd1, 32'd5, 32'd5);
        run_op(2'd1, 32'd5, 32'd5, lat, bcnt, h, l);
        checks++; if ({h, l} !== exp) begin errors++; $display("FAIL flush_restart: got %h expected %h", {h, l}, exp); end
        checks++; if (lat != MUL_LAT) begin errors++; $display("FAIL flush_restart_latency: got %0d expected %0d", lat, MUL_LAT); end
    endtask

    task automatic test_busy_ignore();
        int lat;
        logic [63:0] exp;
        exp = ref_result(2'd3, 32'd100, 32'd7);
        @(negedge clk);
        start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 200) begin
            if (lat == 5) begin start = 1'b1; op = 2'd0; a = 32'd3; b = 32'd3; end
            else start = 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checks++; if ({hi, lo} !== exp) begin errors++; $display("FAIL ignore_result: got %h expected %h", {hi, lo}, exp); end
        checks++; if (lat != DIV_LAT) begin errors++; $display("FAIL ignore_latency: got %0d expected %0d", lat, DIV_LAT); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_queue: got busy=%b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        int          lat, bcnt;
        logic [31:0] h, l;
        logic [63:0] exp;
        run_op(2'd1, 32'hFFFF_FFFF, 32'd2, lat, bcnt, h, l);
        // Still in the DONE cycle: issue the next op immediately.
        start = 1'b1; op = 2'd2; a = 32'hFFFF_FFF9; b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop: got %b expected 0", done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy); end
        lat = 0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        exp = ref_result(2'd2, 32'hFFFF_FFF9, 32'd2);
        checks++; if ({hi, lo} !== exp) begin errors++; $display("FAIL b2b_result: got %h expected %h", {hi, lo}, exp); end
        checks++; if (lat != DIV_LAT) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", lat, DIV_LAT); end
    endtask

    task automatic test_async_reset();
        int          dcnt, lat, bcnt;
        logic [31:0] h, l;
        logic [63:0] exp;
        run_op(2'd0, 32'hFFFF_FFFF, 32'd2, lat, bcnt, h, l);
        @(negedge clk);
        start = 1'b1; op = 2'd0; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        #2 resetn = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL areset_done: got %b expected 0", done); end
        checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL areset_hilo: got %h expected 0", {hi, lo}); end
        @(negedge clk);
        resetn = 1'b1;
        dcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        checks++; if (dcnt != 0) begin errors++; $display("FAIL areset_no_done: got %0d done cycles expected 0", dcnt); end
        exp = ref_result(2'd0, 32'd3, 32'd4);
        run_op(2'd0, 32'd3, 32'd4, lat, bcnt, h, l);
        checks++; if ({h, l} !== exp) begin errors++; $display("FAIL areset_recover: got %h expected %h", {h, l}, exp); end
    endtask

    task automatic test_random();
        int          lat, bcnt;
        logic [1:0]  o;
        logic [31:0] x, y, h, l;
        logic [63:0] exp;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            case ($urandom_range(0, 7))
                0:       y = 32'd0;
                1:       y = 32'($urandom_range(1, 15));
                2:       y = 32'hFFFF_FFFF;
                default: y = $urandom;
            endcase
            exp = ref_result(o, x, y);
            run_op(o, x, y, lat, bcnt, h, l);
            checks++; if ({h, l} !== exp) begin errors++; $display("FAIL rand_result #%0d op=%0d a=%h b=%h: got %h expected %h", i, o, x, y, {h, l}, exp); end
            checks++; if (lat != ref_latency(o)) begin errors++; $display("FAIL rand_latency #%0d op=%0d: got %0d expected %0d", i, o, lat, ref_latency(o)); end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_flush();
        test_busy_ignore();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
